// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares the single-ported unified memory between
// instruction fetch (port 0) and load/store data access (port 1).
// One access is in flight at a time; the winner's address, write data and
// write strobe are registered onto the memory bus, read data is captured
// once the memory latency has elapsed, and a done pulse closes the access.
// Timing seen from a request sampled in IDLE at cycle T:
//   gnt at T+1, write done at T+2, read done (with rdata) at T+2+READ_LATENCY.
module rv32i_mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ROUND_ROBIN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // The counter starts at READ_LATENCY so that the ACCESS state spans the
  // memory latency plus the cycle in which mem_rd_data is captured.
  localparam logic [2:0] LAT_CNT = 3'(READ_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        last_gnt_q, last_gnt_d;
  logic        wr_q, wr_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        mem_wr_ena_q, mem_wr_ena_d;

  logic        both_req;
  logic        winner;

  // Contention: round robin favours the port that did not win last time,
  // otherwise fetch (port 0) always wins; a lone requester always wins.
  assign both_req = req0 & req1;
  assign winner   = both_req ? ((ROUND_ROBIN != 0) ? ~last_gnt_q : 1'b0) : req1;

  // Next-state logic for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    last_gnt_d    = last_gnt_q;
    wr_d          = wr_q;
    rdata_d       = rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_ena_d  = 1'b0;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d       = S_ACCESS;
          sel_d         = winner;
          last_gnt_d    = winner;
          wr_d          = winner ? wr1 : wr0;
          mem_addr_d    = winner ? addr1 : addr0;
          mem_wr_data_d = winner ? wdata1 : wdata0;
          mem_wr_ena_d  = winner ? wr1 : wr0;
          cnt_d         = LAT_CNT;
          gnt0_d        = ~winner;
          gnt1_d        = winner;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_RESP;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = S_RESP;
          rdata_d = mem_rd_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset drops any in-flight access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      sel_q         <= 1'b0;
      last_gnt_q    <= 1'b1;
      wr_q          <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rdata_q       <= 32'd0;
      mem_addr_q    <= 32'd0;
      mem_wr_data_q <= 32'd0;
      mem_wr_ena_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      last_gnt_q    <= last_gnt_d;
      wr_q          <= wr_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_ena_q  <= mem_wr_ena_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = (state_q == S_RESP) && !sel_q;
  assign done1       = (state_q == S_RESP) && sel_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_ena  = mem_wr_ena_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: three arbiter instances (latency 1 round robin,
// latency 1 fixed priority, latency 3 round robin), each with its own
// memory model. Expected accesses are queued when requests are raised and
// checked in order as grants and done pulses appear.
module tb_rv32i_mem_arbiter;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic        req0 [N];
  logic        req1 [N];
  logic        wr0 [N];
  logic        wr1 [N];
  logic [31:0] addr0 [N];
  logic [31:0] addr1 [N];
  logic [31:0] wdata0 [N];
  logic [31:0] wdata1 [N];
  logic        gnt0 [N];
  logic        gnt1 [N];
  logic        done0 [N];
  logic        done1 [N];
  logic        busy [N];
  logic        mem_wr_ena [N];
  logic [31:0] rdata [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wr_data [N];
  logic [31:0] mem_rd_data [N];

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          gnt_delay;
    int          raise_cyc;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cur = 0;
  int    gnt_cyc = 0;
  int    done_count = 0;
  int    viol = 0;
  int    remaining [2];
  logic  prev_done = 1'b0;
  logic  prev_wr_gnt = 1'b0;

  function automatic int lat_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic logic [31:0] init_mem(input logic [7:0] idx);
    if (idx == 8'h04) return 32'h00500093;
    return {8'hA5, idx, 8'h5A, idx};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int RR  = (g == 1) ? 0 : 1;
    logic [31:0] mem [0:255];
    logic [31:0] pipe [0:LAT-1];

    rv32i_mem_arbiter #(.READ_LATENCY(LAT), .ROUND_ROBIN(RR)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .req1(req1[g]),
      .addr0(addr0[g]), .addr1(addr1[g]),
      .wr0(wr0[g]), .wr1(wr1[g]),
      .wdata0(wdata0[g]), .wdata1(wdata1[g]),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]),
      .done0(done0[g]), .done1(done1[g]),
      .rdata(rdata[g]), .busy(busy[g]),
      .mem_addr(mem_addr[g]), .mem_wr_data(mem_wr_data[g]),
      .mem_wr_ena(mem_wr_ena[g]), .mem_rd_data(mem_rd_data[g])
    );

    // Memory model: read data appears LAT cycles after the address.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_mem(8'(i));
      end else if (mem_wr_ena[g]) begin
        mem[mem_addr[g][9:2]] <= mem_wr_data[g];
      end
      pipe[0] <= mem[mem_addr[g][9:2]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rd_data[g] = pipe[LAT-1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic releaseReq(input int port);
    if (port == 0) req0[cur] = 1'b0;
    else           req1[cur] = 1'b0;
  endtask

  task automatic releaseAll();
    for (int g = 0; g < N; g++) begin
      req0[g] = 1'b0;
      req1[g] = 1'b0;
    end
    remaining[0] = 0;
    remaining[1] = 0;
  endtask

  task automatic applyStimulus(input int port, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input int n_grants, input int gnt_delay);
    item_t it;
    it.port      = port;
    it.wr        = wr;
    it.addr      = addr;
    it.wdata     = wdata;
    it.data      = exp_data;
    it.raise_cyc = cyc;
    for (int i = 0; i < n_grants; i++) begin
      it.gnt_delay = (i == 0) ? gnt_delay : -1;
      sbq.push_back(it);
    end
    remaining[port] = n_grants;
    if (port == 0) begin
      wr0[cur] = wr; addr0[cur] = addr; wdata0[cur] = wdata; req0[cur] = 1'b1;
    end else begin
      wr1[cur] = wr; addr1[cur] = addr; wdata1[cur] = wdata; req1[cur] = 1'b1;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("wait_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
      releaseAll();
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    releaseAll();
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkResetState(input int g);
    checkOutput("rst_gnt0", 32'(gnt0[g]), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1[g]), 32'd0);
    checkOutput("rst_done0", 32'(done0[g]), 32'd0);
    checkOutput("rst_done1", 32'(done1[g]), 32'd0);
    checkOutput("rst_busy", 32'(busy[g]), 32'd0);
    checkOutput("rst_wr_ena", 32'(mem_wr_ena[g]), 32'd0);
    checkOutput("rst_rdata", rdata[g], 32'd0);
    checkOutput("rst_mem_addr", mem_addr[g], 32'd0);
    checkOutput("rst_mem_wr_data", mem_wr_data[g], 32'd0);
  endtask

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  initial begin
    logic  got_gnt;
    logic  got_done;
    item_t it;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        prev_done   = 1'b0;
        prev_wr_gnt = 1'b0;
      end else begin
        got_gnt  = gnt0[cur] | gnt1[cur];
        got_done = done0[cur] | done1[cur];
        if (prev_wr_gnt) checkOutput("wr_ena_one_cycle", 32'(mem_wr_ena[cur]), 32'd0);
        if (prev_done)   checkOutput("busy_after_done", 32'(busy[cur]), 32'd0);
        prev_wr_gnt = 1'b0;
        prev_done   = 1'b0;
        if ((gnt0[cur] && gnt1[cur]) || (done0[cur] && done1[cur]) || (got_gnt && got_done))
          viol++;
        if (got_gnt) begin
          if (sbq.size() == 0) begin
            checkOutput("gnt_unexpected", 32'(got_gnt), 32'd0);
          end else begin
            it = sbq[0];
            checkOutput("gnt_port", 32'(gnt1[cur]), 32'(it.port));
            checkOutput("gnt_mem_addr", mem_addr[cur], it.addr);
            checkOutput("gnt_wr_ena", 32'(mem_wr_ena[cur]), 32'(it.wr));
            if (it.wr) checkOutput("gnt_wr_data", mem_wr_data[cur], it.wdata);
            if (it.gnt_delay > 0)
              checkOutput("gnt_time", 32'(cyc - it.raise_cyc), 32'(it.gnt_delay));
            checkOutput("busy_at_gnt", 32'(busy[cur]), 32'd1);
            gnt_cyc     = cyc;
            prev_wr_gnt = it.wr;
            if (remaining[it.port] > 0) remaining[it.port]--;
            if (remaining[it.port] == 0) releaseReq(it.port);
          end
        end
        if (got_done) begin
          done_count++;
          if (sbq.size() == 0) begin
            checkOutput("done_unexpected", 32'(got_done), 32'd0);
          end else begin
            it = sbq.pop_front();
            checkOutput("done_port", 32'(done1[cur]), 32'(it.port));
            checkOutput("done_time", 32'(cyc - gnt_cyc),
                        it.wr ? 32'd1 : 32'(lat_of(cur) + 1));
            if (!it.wr) checkOutput("rdata", rdata[cur], it.data);
            checkOutput("busy_at_done", 32'(busy[cur]), 32'd1);
            prev_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: each phase selects one instance and waits for it to drain.
  initial begin
    int saved;
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      req0[g] = 1'b0; req1[g] = 1'b0; wr0[g] = 1'b0; wr1[g] = 1'b0;
      addr0[g] = 32'd0; addr1[g] = 32'd0; wdata0[g] = 32'd0; wdata1[g] = 32'd0;
    end
    doReset();
    for (int g = 0; g < N; g++) checkResetState(g);

    // Basic fetch read, data write, read-back of the written word.
    cur = 0;
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h00500093, 1, 1);
    waitIdle();
    applyStimulus(1, 1'b1, 32'h20, 32'hDEADBEEF, 32'd0, 1, 1);
    waitIdle();
    applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'hDEADBEEF, 1, 1);
    waitIdle();

    // Round robin: port 0 wins first after reset, then alternation.
    doReset();
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h00500093, 1, 1);
    applyStimulus(1, 1'b0, 32'h44, 32'd0, init_mem(8'h11), 1, -1);
    waitIdle();
    applyStimulus(0, 1'b0, 32'h48, 32'd0, init_mem(8'h12), 1, 1);
    waitIdle();
    applyStimulus(1, 1'b0, 32'h4C, 32'd0, init_mem(8'h13), 1, 1);
    applyStimulus(0, 1'b0, 32'h50, 32'd0, init_mem(8'h14), 1, -1);
    waitIdle();

    // Fixed priority: port 1 waits while port 0 keeps requesting.
    cur = 1;
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h00500093, 4, 1);
    applyStimulus(1, 1'b0, 32'h24, 32'd0, init_mem(8'h09), 1, -1);
    waitIdle();

    // Latency 3: longer read, write timing unchanged, read-back.
    cur = 2;
    applyStimulus(0, 1'b0, 32'h40, 32'd0, init_mem(8'h10), 1, 1);
    waitIdle();
    applyStimulus(1, 1'b1, 32'h60, 32'h12345678, 32'd0, 1, 1);
    waitIdle();
    applyStimulus(1, 1'b0, 32'h60, 32'd0, 32'h12345678, 1, 1);
    waitIdle();

    // Reset while a read is in ACCESS: no done, outputs cleared, then recovery.
    cur = 0;
    saved = done_count;
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h00500093, 1, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_before_rst", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    sbq.delete();
    releaseAll();
    @(negedge clk);
    rst = 1'b0;
    checkResetState(0);
    repeat (6) @(negedge clk);
    checkOutput("no_done_after_rst", 32'(done_count - saved), 32'd0);
    applyStimulus(0, 1'b0, 32'h40, 32'd0, init_mem(8'h10), 1, 1);
    waitIdle();

    checkOutput("protocol_violations", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
